// File: rtl/text_overlay_if.sv
// Pixel-request and string-write bundle for the text overlay renderer.
// The master drives writes, frame/blink control and pixel coordinates; the slave returns the lit bit.
interface text_overlay_if #(
  parameter int unsigned MAX_CHARS = 16
) ();
  localparam int unsigned AW = $clog2(MAX_CHARS);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [5:0]    wr_char;
  logic [AW:0]   wr_len;
  logic          frame_start;
  logic          blink_en;
  logic          pix_valid;
  logic [9:0]    pix_x;
  logic [8:0]    pix_y;
  logic          out_valid;
  logic          out_on;

  modport master (
    output wr_en, wr_addr, wr_char, wr_len, frame_start, blink_en,
    output pix_valid, pix_x, pix_y,
    input  out_valid, out_on
  );

  modport slave (
    input  wr_en, wr_addr, wr_char, wr_len, frame_start, blink_en,
    input  pix_valid, pix_x, pix_y,
    output out_valid, out_on
  );
endinterface

// File: rtl/text_overlay.sv
// Renders a double-buffered string of 5x7 glyphs at a fixed origin with power-of-two scaling and blinking.
// One lit/unlit bit per pixel request, fixed two-cycle latency, no stalls.
module text_overlay #(
  parameter int unsigned MAX_CHARS    = 16,
  parameter int unsigned X0           = 16,
  parameter int unsigned Y0           = 8,
  parameter int unsigned SCALE_LOG2   = 1,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input logic            clk,
  input logic            resetn,
  text_overlay_if.slave  bus
);
  localparam int unsigned AW = $clog2(MAX_CHARS);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 8;

  // Glyph bitmaps, row 0 in the top five bits, bit 4 of each row is the leftmost column.
  function automatic logic [34:0] glyph(input logic [5:0] code);
    logic [34:0] g;
    g = '0;
    case (code)
      6'd1:  g = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
      6'd2:  g = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      6'd3:  g = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
      6'd4:  g = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
      6'd5:  g = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
      6'd6:  g = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
      6'd7:  g = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
      6'd8:  g = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
      6'd9:  g = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
      6'd10: g = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
      6'd11: g = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11};
      6'd12: g = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E};
      6'd13: g = {5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E};
      6'd14: g = {5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C};
      6'd15: g = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
      6'd16: g = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10};
      6'd17: g = {5'h0E, 5'h11, 5'h10, 5'h17, 5'h11, 5'h11, 5'h0F};
      6'd18: g = {5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
      6'd19: g = {5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      6'd20: g = {5'h07, 5'h02, 5'h02, 5'h02, 5'h02, 5'h12, 5'h0C};
      6'd21: g = {5'h11, 5'h12, 5'h14, 5'h18, 5'h14, 5'h12, 5'h11};
      6'd22: g = {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F};
      6'd23: g = {5'h11, 5'h1B, 5'h15, 5'h15, 5'h11, 5'h11, 5'h11};
      6'd24: g = {5'h11, 5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11};
      6'd25: g = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
      6'd26: g = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h10, 5'h10};
      6'd27: g = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h15, 5'h12, 5'h0D};
      6'd28: g = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h14, 5'h12, 5'h11};
      6'd29: g = {5'h0F, 5'h10, 5'h10, 5'h0E, 5'h01, 5'h01, 5'h1E};
      6'd30: g = {5'h1F, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04};
      6'd31: g = {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
      6'd32: g = {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0A, 5'h04};
      6'd33: g = {5'h11, 5'h11, 5'h11, 5'h15, 5'h15, 5'h15, 5'h0A};
      6'd34: g = {5'h11, 5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11, 5'h11};
      6'd35: g = {5'h11, 5'h11, 5'h11, 5'h0A, 5'h04, 5'h04, 5'h04};
      6'd36: g = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F};
      default: g = '0;
    endcase
    return g;
  endfunction

  // Gap column (5) and out-of-range rows read as unlit.
  function automatic logic font_bit(input logic [34:0] g, input logic [2:0] row,
                                    input logic [2:0] col);
    logic [4:0] bits;
    int         base;
    logic       b;
    bits = '0;
    b    = 1'b0;
    if (row < 3'd7) begin
      base = 34 - 5 * int'(row);
      bits = g[base -: 5];
    end
    if (col < 3'd5) b = bits[3'd4 - col];
    return b;
  endfunction

  logic [5:0]    sh_chars_q  [MAX_CHARS];
  logic [5:0]    act_chars_q [MAX_CHARS];
  logic [LW-1:0] sh_len_q, sh_len_d;
  logic [LW-1:0] act_len_q;
  logic [CW-1:0] frame_cnt_q;
  logic          blink_phase_q;

  logic          s1_valid_q, s1_inside_q;
  logic [AW-1:0] s1_ci_q;
  logic [2:0]    s1_row_q, s1_col_q;
  logic          out_valid_q, out_on_q, out_on_d;

  logic [10:0]   dx_c, dy_c, fx_c, fy_c, ci_c;
  logic          inside_c;

  assign sh_len_d = (bus.wr_len > LW'(MAX_CHARS)) ? LW'(MAX_CHARS) : bus.wr_len;

  // Shadow written by the host; active bank snapshots the pre-write shadow at frame start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(MAX_CHARS); i++) begin
        sh_chars_q[i]  <= '0;
        act_chars_q[i] <= '0;
      end
      sh_len_q  <= '0;
      act_len_q <= '0;
    end else begin
      if (bus.frame_start) begin
        act_chars_q <= sh_chars_q;
        act_len_q   <= sh_len_q;
      end
      if (bus.wr_en) begin
        sh_chars_q[bus.wr_addr] <= bus.wr_char;
        sh_len_q                <= sh_len_d;
      end
    end
  end

  // Blink half-period counter, free-running regardless of blink_en.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (bus.frame_start) begin
      if (frame_cnt_q == CW'(BLINK_FRAMES - 1)) begin
        frame_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + CW'(1);
      end
    end
  end

  // Wrapping subtraction is safe: the explicit >= origin compares reject underflowed values.
  always_comb begin
    dx_c     = 11'(bus.pix_x) - 11'(X0);
    dy_c     = 11'(bus.pix_y) - 11'(Y0);
    fx_c     = dx_c >> SCALE_LOG2;
    fy_c     = dy_c >> SCALE_LOG2;
    ci_c     = fx_c / 11'd6;
    inside_c = (11'(bus.pix_x) >= 11'(X0)) && (11'(bus.pix_y) >= 11'(Y0)) &&
               (fy_c < 11'd7) && (ci_c < 11'(act_len_q));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q  <= 1'b0;
      s1_inside_q <= 1'b0;
      s1_ci_q     <= '0;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
    end else begin
      s1_valid_q  <= bus.pix_valid;
      s1_inside_q <= inside_c;
      s1_ci_q     <= AW'(ci_c);
      s1_row_q    <= 3'(fy_c);
      s1_col_q    <= 3'(fx_c % 11'd6);
    end
  end

  always_comb begin
    out_on_d = 1'b0;
    if (s1_valid_q && s1_inside_q)
      out_on_d = font_bit(glyph(act_chars_q[s1_ci_q]), s1_row_q, s1_col_q) &&
                 !(bus.blink_en && blink_phase_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_on_q    <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      out_on_q    <= out_on_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_on    = out_on_q;
endmodule

// File: tb/tb_text_overlay.sv
// Directed bench for text_overlay: double buffering, geometry, font lookup, blinking and reset.
module tb_text_overlay;
  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_err;

  text_overlay_if #(.MAX_CHARS(16)) ovl ();

  text_overlay #(
    .MAX_CHARS(16), .X0(16), .Y0(8), .SCALE_LOG2(1), .BLINK_FRAMES(30)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ovl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk) resetn = 1'b0;
    ovl.blink_en = 1'b0;
    @(negedge clk) resetn = 1'b1;
  endtask

  task automatic write_char(input int addr, input int code, input int len);
    @(negedge clk);
    ovl.wr_en   = 1'b1;
    ovl.wr_addr = 4'(addr);
    ovl.wr_char = 6'(code);
    ovl.wr_len  = 5'(len);
    @(negedge clk) ovl.wr_en = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk) ovl.frame_start = 1'b1;
    @(negedge clk) ovl.frame_start = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  // Issues one pixel and returns {out_valid, out_on} sampled two edges later.
  task automatic probe(input int x, input int y, output logic [1:0] r);
    @(negedge clk);
    ovl.pix_valid = 1'b1;
    ovl.pix_x     = 10'(x);
    ovl.pix_y     = 9'(y);
    @(negedge clk) ovl.pix_valid = 1'b0;
    @(negedge clk) r = {ovl.out_valid, ovl.out_on};
  endtask

  task automatic test_reset();
    logic [1:0] r;
    @(negedge clk);
    @(negedge clk);
    r = {ovl.out_valid, ovl.out_on};
    n_cmp++;
    if (r !== 2'b00) begin n_err++; $display("FAIL reset_outputs: got %b want 00", r); end
    @(negedge clk) resetn = 1'b1;
    @(negedge clk);
    r = {ovl.out_valid, ovl.out_on};
    n_cmp++;
    if (r !== 2'b00) begin n_err++; $display("FAIL reset_idle: got %b want 00", r); end
    probe(18, 8, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL reset_len0: got %b want 10", r); end
  endtask

  task automatic test_basic();
    logic [1:0] r;
    write_char(0, 1, 1);
    frame();
    probe(16, 8, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL basic_16_8: got %b want 10", r); end
    probe(18, 8, r);
    n_cmp++;
    if (r !== 2'b11) begin n_err++; $display("FAIL basic_18_8: got %b want 11", r); end
    probe(19, 8, r);
    n_cmp++;
    if (r !== 2'b11) begin n_err++; $display("FAIL basic_19_8_scale: got %b want 11", r); end
    probe(16, 10, r);
    n_cmp++;
    if (r !== 2'b11) begin n_err++; $display("FAIL basic_row1_col0: got %b want 11", r); end
    probe(18, 10, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL basic_row1_col1: got %b want 10", r); end
  endtask

  task automatic test_bounds();
    logic [1:0] r;
    probe(26, 8, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL bounds_gap: got %b want 10", r); end
    probe(28, 8, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL bounds_past_len: got %b want 10", r); end
    probe(15, 8, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL bounds_left: got %b want 10", r); end
    probe(18, 22, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL bounds_row7: got %b want 10", r); end
    probe(0, 8, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL bounds_underflow_x: got %b want 10", r); end
    probe(18, 0, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL bounds_underflow_y: got %b want 10", r); end
  endtask

  task automatic test_back_to_back();
    int         xs  [4] = '{16, 18, 19, 26};
    logic [1:0] exp [4] = '{2'b10, 2'b11, 2'b11, 2'b10};
    logic [1:0] r;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        r = {ovl.out_valid, ovl.out_on};
        n_cmp++;
        if (r !== exp[i-2]) begin
          n_err++; $display("FAIL b2b_%0d: got %b want %b", i - 2, r, exp[i-2]);
        end
      end
      ovl.pix_valid = (i < 4);
      ovl.pix_x     = (i < 4) ? 10'(xs[i]) : 10'd0;
      ovl.pix_y     = 9'd8;
    end
    ovl.pix_valid = 1'b0;
  endtask

  task automatic test_shadow();
    logic [1:0] r;
    do_reset();
    write_char(0, 1, 1);
    probe(18, 8, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL shadow_before_frame: got %b want 10", r); end
    frame();
    probe(18, 8, r);
    n_cmp++;
    if (r !== 2'b11) begin n_err++; $display("FAIL shadow_after_frame: got %b want 11", r); end
  endtask

  task automatic test_same_cycle();
    logic [1:0] r;
    do_reset();
    @(negedge clk);
    ovl.wr_en = 1'b1; ovl.wr_addr = 4'd0; ovl.wr_char = 6'd1; ovl.wr_len = 5'd1;
    ovl.frame_start = 1'b1;
    @(negedge clk);
    ovl.wr_en = 1'b0; ovl.frame_start = 1'b0;
    probe(18, 8, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL same_cycle_this_frame: got %b want 10", r); end
    frame();
    probe(18, 8, r);
    n_cmp++;
    if (r !== 2'b11) begin n_err++; $display("FAIL same_cycle_next_frame: got %b want 11", r); end
  endtask

  task automatic test_clamp_and_codes();
    logic [1:0] r;
    do_reset();
    write_char(15, 1, 31);
    write_char(0, 1, 31);
    write_char(1, 40, 31);
    write_char(3, 11, 31);
    frame();
    probe(198, 8, r);
    n_cmp++;
    if (r !== 2'b11) begin n_err++; $display("FAIL clamp_slot15: got %b want 11", r); end
    probe(210, 8, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL clamp_slot16: got %b want 10", r); end
    probe(30, 8, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL blank_code40: got %b want 10", r); end
    probe(52, 16, r);
    n_cmp++;
    if (r !== 2'b11) begin n_err++; $display("FAIL glyph_A_row4: got %b want 11", r); end
    probe(52, 8, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL glyph_A_row0: got %b want 10", r); end
  endtask

  task automatic test_blink();
    logic [1:0] r;
    do_reset();
    write_char(0, 1, 1);
    frame();
    ovl.blink_en = 1'b1;
    frames(28);
    probe(18, 8, r);
    n_cmp++;
    if (r !== 2'b11) begin n_err++; $display("FAIL blink_29_pulses: got %b want 11", r); end
    frames(1);
    probe(18, 8, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL blink_30_pulses: got %b want 10", r); end
    frames(1);
    probe(18, 8, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL blink_31_pulses: got %b want 10", r); end
    ovl.blink_en = 1'b0;
    probe(18, 8, r);
    n_cmp++;
    if (r !== 2'b11) begin n_err++; $display("FAIL blink_disabled: got %b want 11", r); end
    ovl.blink_en = 1'b1;
    frames(28);
    probe(18, 8, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL blink_59_pulses: got %b want 10", r); end
    frames(1);
    probe(18, 8, r);
    n_cmp++;
    if (r !== 2'b11) begin n_err++; $display("FAIL blink_60_pulses: got %b want 11", r); end
    frames(1);
    probe(18, 8, r);
    n_cmp++;
    if (r !== 2'b11) begin n_err++; $display("FAIL blink_61_pulses: got %b want 11", r); end
    ovl.blink_en = 1'b0;
  endtask

  task automatic test_reset_mid_stream();
    logic [1:0] r;
    do_reset();
    write_char(0, 1, 1);
    frame();
    @(negedge clk);
    ovl.pix_valid = 1'b1; ovl.pix_x = 10'd18; ovl.pix_y = 9'd8;
    @(negedge clk);
    @(negedge clk);
    r = {ovl.out_valid, ovl.out_on};
    n_cmp++;
    if (r !== 2'b11) begin n_err++; $display("FAIL midrst_streaming: got %b want 11", r); end
    @(posedge clk);
    #2 resetn = 1'b0;
    #1 r = {ovl.out_valid, ovl.out_on};
    n_cmp++;
    if (r !== 2'b00) begin n_err++; $display("FAIL midrst_async_drop: got %b want 00", r); end
    @(negedge clk) resetn = 1'b1;
    @(negedge clk);
    r = {ovl.out_valid, ovl.out_on};
    n_cmp++;
    if (r !== 2'b00) begin n_err++; $display("FAIL midrst_one_edge: got %b want 00", r); end
    @(negedge clk);
    r = {ovl.out_valid, ovl.out_on};
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL midrst_empty_string: got %b want 10", r); end
    ovl.pix_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    resetn          = 1'b0;
    ovl.wr_en       = 1'b0;
    ovl.wr_addr     = '0;
    ovl.wr_char     = '0;
    ovl.wr_len      = '0;
    ovl.frame_start = 1'b0;
    ovl.blink_en    = 1'b0;
    ovl.pix_valid   = 1'b0;
    ovl.pix_x       = '0;
    ovl.pix_y       = '0;

    test_reset();
    test_basic();
    test_bounds();
    test_back_to_back();
    test_shadow();
    test_same_cycle();
    test_clamp_and_codes();
    test_blink();
    test_reset_mid_stream();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/text_overlay.md
Name: text_overlay

Overview:
- Parametrised on-screen text renderer for the VGA path: replaces the fixed "score"/"high score" bitmap constants.
- Holds a writable string of up to MAX_CHARS characters and renders it from a 5x7 font ROM at a fixed origin, with integer power-of-two scaling and optional blinking.
- Returns one on/off pixel bit per incoming pixel coordinate, two cycles later, for the pixel mux ahead of the VGA adapter.

Parameters:
- MAX_CHARS, 16, string capacity in characters.
- X0, 16, left pixel column of the text box.
- Y0, 8, top pixel row of the text box.
- SCALE_LOG2, 1, each font pixel drawn as (1<<SCALE_LOG2) square screen pixels.
- BLINK_FRAMES, 30, frames per blink half-period.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- wr_en  in  1  write one character to the shadow string.
- wr_addr  in  $clog2(MAX_CHARS)  character slot.
- wr_char  in  6  code: 0 space, 1-10 digits 0-9, 11-36 A-Z, 37-63 blank.
- wr_len  in  $clog2(MAX_CHARS)+1  shadow length, sampled on every wr_en.
- frame_start  in  1  one-cycle pulse at start of each frame.
- blink_en  in  1  enable blinking.
- pix_valid  in  1  pix_x/pix_y valid this cycle.
- pix_x  in  10  pixel column.
- pix_y  in  9  pixel row.
- out_valid  out  1  pix_valid delayed two cycles.
- out_on  out  1  text pixel lit, aligned with out_valid.

Behaviour:
- Storage:
  - Shadow bank: char regs plus length, written by wr_en.
  - Active bank: copied whole from shadow on frame_start; rendering reads only the active bank, so there is no mid-frame tearing.
  - wr_en and frame_start in the same cycle: the copy takes pre-write shadow contents; the write becomes visible next frame.
  - wr_len > MAX_CHARS is clamped to MAX_CHARS at write.
- Geometry:
  - S = 1<<SCALE_LOG2; cell = 6x7 font pixels (5 glyph columns + 1 gap column).
  - dx = pix_x-X0, dy = pix_y-Y0, both unsigned 11-bit.
  - Inside box iff pix_x>=X0, pix_y>=Y0, dy>>SCALE_LOG2 < 7, and char index ci = (dx>>SCALE_LOG2)/6 < active length.
  - col = (dx>>SCALE_LOG2) mod 6; row = dy>>SCALE_LOG2.
  - col 5 (gap) is always off.
- Font ROM: 37 glyphs x 7 rows x 5 bits, from the team's standard 5x7 font table; bit 4 is the leftmost column.
- Pipeline, fixed latency 2, no stalls:
  - Stage 1 registers the inside flag, ci, row and col.
  - Stage 2 registers active-bank lookup, ROM bit, and blink mask.
  - out_valid = pix_valid delayed 2 cycles; out_on = 0 whenever out_valid = 0.
- Blink:
  - 8-bit frame counter counts frame_start pulses, 0..BLINK_FRAMES-1; on reaching BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase.
  - When blink_en=1 and blink_phase=1, out_on is forced 0.
  - blink_en does not stop or reset the counter.
- Reset (resetn low, asynchronous):
  - All char slots = 0 (space), both lengths = 0.
  - Counter = 0, blink_phase = 0.
  - Pipeline valids = 0, out_valid = 0, out_on = 0.
  - In-flight pixels are discarded; the first valid output comes 2 cycles after the first pix_valid following reset release.
- Boundaries:
  - Length 0 renders nothing.
  - Codes 37-63 render blank cells but still occupy a slot.
  - pix_x < X0 must not underflow into a hit.

Test Plan:
- Reset, write slot 0 = code 1 ('0'), wr_len=1, pulse frame_start; pix (16,8) -> 2 cycles later out_valid=1, out_on=0; pix (18,8) -> out_on=1 (row 0 of '0' = 01110).
- Same string; pix (26,8) (col 5 gap) -> out_on=0; pix (28,8) (ci=1 >= len) -> out_on=0; pix (15,8) and (18,22) -> out_on=0.
- Write slot 0 = '0' with wr_len=1 and no frame_start; pix (18,8) -> out_on=0; pulse frame_start -> out_on=1.
- Raise wr_en and frame_start in the same cycle -> new char absent this frame, present after the next frame_start.
- Write slot 0 = '0' with wr_len=1, pulse frame_start, set blink_en=1, then issue 30 more frame_start pulses -> blink_phase=1 and pix (18,8) gives out_on=0; after 30 further pulses -> out_on=1.
- Assert resetn low mid-stream with pix_valid streaming -> out_valid and out_on drop immediately; string empty after release.
